// File: rtl/dmem_ctrl_if.sv
// Data-memory bus: one valid/ready request channel and one response channel.
// The controller takes the master modport and the memory takes the slave modport.
interface dmem_ctrl_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_write;
    logic [63:0] bus_req_addr;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_be;
    logic        bus_rsp_valid;
    logic [63:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    modport master (
        output bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_be,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_be,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: issues one bus request per MEM access, stalls the
// pipeline until the response arrives or the timeout expires, and flags faults.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_byte_en,
    output logic        stall,
    output logic [63:0] rsp_rdata,
    output logic        access_fault,
    dmem_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic        wr_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  be_q;
    logic [15:0] cnt;
    logic        fault_q;
    logic        hs;
    logic        rsp_take;
    logic        timeout;
    logic        abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        hs       = (state == REQ) && bus.bus_req_ready;
        rsp_take = (state == WAIT) && bus.bus_rsp_valid;
        timeout  = ((state == REQ) || (state == WAIT)) && (cnt == TO_LAST);
        // a handshake or response in the timeout cycle completes the state first
        abort    = timeout && !hs && !rsp_take;
        unique case (state)
            IDLE: if (req_valid) state_nx = REQ;
            REQ: begin
                if (hs)         state_nx = WAIT;
                else if (abort) state_nx = DONE;
            end
            WAIT: if (rsp_take || abort) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cnt       <= '0;
            fault_q   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_byte_en;
                        cnt     <= '0;
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (rsp_take) begin
                        fault_q <= bus.bus_rsp_err;
                        if (!wr_q) rsp_rdata <= bus.bus_rsp_err ? '0 : bus.bus_rsp_rdata;
                    end else if (abort) begin
                        fault_q <= 1'b1;
                        if (!wr_q) rsp_rdata <= '0;
                    end
                end
                DONE: fault_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.bus_req_valid = (state == REQ);
    assign bus.bus_req_write = wr_q;
    assign bus.bus_req_addr  = addr_q;
    assign bus.bus_req_wdata = wdata_q;
    assign bus.bus_req_be    = be_q;

    assign stall        = req_valid && (state != DONE) && !rst;
    assign access_fault = (state == DONE) && fault_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl: each access is scored against a latency/result
// model computed from the ready delay, response delay and timeout window.
module tb_dmem_ctrl;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_byte_en;
    logic        stall;
    logic [63:0] rsp_rdata;
    logic        access_fault;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_byte_en  (req_byte_en),
        .stall        (stall),
        .rsp_rdata    (rsp_rdata),
        .access_fault (access_fault),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] model_rdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access: ready comes after dr refused REQ cycles, response ds cycles into WAIT.
    task automatic run_access(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [7:0] be, input int dr, input int ds,
                              input logic [63:0] rdata, input logic err);
        int          rsp_at, done_k, req_cycles, done_at, req_seen;
        bit          normal, bus_ok;
        logic        exp_fault, got_fault;
        logic [63:0] exp_rd, got_rd;

        rsp_at     = dr + 1 + ds;
        normal     = (rsp_at <= T - 1);
        done_k     = normal ? rsp_at + 1 : T;
        req_cycles = (dr + 1 < T) ? dr + 1 : T;
        exp_fault  = normal ? err : 1'b1;
        exp_rd     = wr ? model_rdata : (normal ? (err ? 64'd0 : rdata) : 64'd0);

        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = wr;
        req_addr    = addr;
        req_wdata   = wdata;
        req_byte_en = be;
        done_at  = -1;
        req_seen = 0;
        bus_ok   = 1'b1;
        got_fault = 1'b0;
        got_rd    = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
            bus.bus_req_ready = (cyc == dr + 1);
            bus.bus_rsp_valid = normal && (cyc == rsp_at + 1);
            bus.bus_rsp_rdata = (cyc == rsp_at + 1) ? rdata : {$urandom, $urandom};
            bus.bus_rsp_err   = (cyc == rsp_at + 1) ? err : 1'($urandom);
            #1;
            if (bus.bus_req_valid) begin
                req_seen++;
                if (bus.bus_req_write !== wr || bus.bus_req_addr !== addr ||
                    bus.bus_req_wdata !== wdata || bus.bus_req_be !== be)
                    bus_ok = 1'b0;
            end
            if (!stall) begin
                done_at   = cyc;
                got_fault = access_fault;
                got_rd    = rsp_rdata;
                break;
            end
        end
        check("done_bound", 64'(done_at >= 0), 64'd1);
        check("stall_cycles", 64'(done_at), 64'(done_k + 1));
        check("req_valid_cycles", 64'(req_seen), 64'(req_cycles));
        check("bus_fields", 64'(bus_ok), 64'd1);
        check("fault", 64'(got_fault), 64'(exp_fault));
        check("rsp_rdata", got_rd, exp_rd);
        model_rdata = exp_rd;

        @(negedge clk);
        req_valid         = 1'b0;
        bus.bus_req_ready = 1'b0;
        bus.bus_rsp_valid = 1'b0;
        #1;
        check("fault_pulse_end", 64'(access_fault), 64'd0);
    endtask

    initial begin
        int          dr, ds;
        logic        wr, err;
        logic [63:0] addr;

        rst = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_byte_en = '0;
        bus.bus_req_ready = 1'b0;
        bus.bus_rsp_valid = 1'b0;
        bus.bus_rsp_rdata = '0;
        bus.bus_rsp_err   = 1'b0;
        #12;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_req_valid", 64'(bus.bus_req_valid), 64'd0);
        check("rst_req_addr", bus.bus_req_addr, 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_fault", 64'(access_fault), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;

        // zero-wait load, store, backpressure, error response
        run_access(1'b0, 64'h1000, 64'h0, 8'hff, 0, 0, 64'h1122334455667788, 1'b0);
        run_access(1'b1, 64'h2008, 64'h00000000AB000000, 8'h08, 0, 0, 64'hdeadbeefdeadbeef, 1'b0);
        run_access(1'b0, 64'h3000, 64'h0, 8'hff, 3, 0, 64'hcafef00d12345678, 1'b0);
        run_access(1'b0, 64'h4000, 64'h0, 8'hff, 0, 1, 64'h5555aaaa5555aaaa, 1'b1);

        // response landing exactly in the timeout cycle still wins
        run_access(1'b0, 64'h4800, 64'h0, 8'hff, 2, 4, 64'h0102030405060708, 1'b0);

        // timeout with no response, then a late response must be ignored
        run_access(1'b0, 64'h5000, 64'h0, 8'hff, 0, 40, 64'h0, 1'b0);
        @(negedge clk);
        bus.bus_rsp_valid = 1'b1;
        bus.bus_rsp_rdata = 64'hffffffffffffffff;
        bus.bus_rsp_err   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("late_rsp_fault", 64'(access_fault), 64'd0);
            check("late_rsp_req", 64'(bus.bus_req_valid), 64'd0);
            @(negedge clk);
            bus.bus_rsp_valid = 1'b0;
        end
        check("late_rsp_rdata", rsp_rdata, model_rdata);

        // timeout while the request is still refused
        run_access(1'b0, 64'h5800, 64'h0, 8'hff, T + 2, 0, 64'h0, 1'b0);

        // give rsp_rdata a non-zero value, then reset in the middle of WAIT
        run_access(1'b0, 64'h6000, 64'h0, 8'hff, 0, 0, 64'h0badc0de0badc0de, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h7000;
        @(negedge clk);
        bus.bus_req_ready = 1'b1;
        @(negedge clk);
        bus.bus_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_req_valid", 64'(bus.bus_req_valid), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_fault", 64'(access_fault), 64'd0);
        check("midrst_rdata", rsp_rdata, 64'd0);
        model_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        run_access(1'b0, 64'h7000, 64'h0, 8'hff, 1, 1, 64'h8877665544332211, 1'b0);

        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom);
            addr = {$urandom, $urandom} & ~64'h7;
            dr   = int'($urandom_range(0, T + 1));
            if (dr == T - 1) dr = T + 1;
            ds   = int'($urandom_range(0, T));
            err  = ($urandom_range(0, 4) == 0);
            run_access(wr, addr, {$urandom, $urandom}, 8'($urandom), dr, ds,
                       {$urandom, $urandom}, err);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between `mem_stage` and the external data-memory bus. It latches the aligned address, store data and byte enables produced in MEM and issues them as a single valid/ready bus request. It waits for a variable-latency response, returns load data to `mem_stage` as `dmem_rdata`, and holds the pipeline with `stall` until the access completes. Bus error responses and response timeouts are reported as a one-cycle `access_fault`.

## Interface
- `TIMEOUT_CYCLES`, 256: cycles allowed in REQ+WAIT before abort; legal range 1..65535.

- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: MEM holds a valid load or store (`(mem_read|mem_write) && valid`).
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 64: 8-byte-aligned address (`dmem_addr`).
- `req_wdata` in 64: lane-shifted store data (`dmem_wdata`).
- `req_byte_en` in 8: byte lane enables (`dmem_byte_en`).
- `stall` out 1: freeze IF..MEM pipeline registers.
- `rsp_rdata` out 64: raw 64-bit read data to `mem_stage.dmem_rdata`.
- `access_fault` out 1: one-cycle pulse on bus error or timeout.
- `bus_req_valid` out 1: bus request valid.
- `bus_req_ready` in 1: bus accepts request.
- `bus_req_write` out 1: bus request is a write.
- `bus_req_addr` out 64: bus request address.
- `bus_req_wdata` out 64: bus write data.
- `bus_req_be` out 8: bus byte enables.
- `bus_rsp_valid` in 1: response valid; one per accepted request, for reads and writes alike.
- `bus_rsp_rdata` in 64: response read data.
- `bus_rsp_err` in 1: response carries an error.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - On `req_valid`: latch write/addr/wdata/byte_en into request registers, clear the timeout counter, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `bus_req_valid`=1 with the latched fields. The fields are stable until the handshake.
  - `bus_req_valid && bus_req_ready` → WAIT.
- **WAIT**
  - On `bus_rsp_valid`, go to DONE.
  - For a load: `rsp_rdata` ← `bus_rsp_rdata`, or ← 0 if `bus_rsp_err`.
  - For a store: `rsp_rdata` is unchanged.
  - On `bus_rsp_err`: set the fault flag.
- **Timeout**
  - The counter (16 bit) increments every cycle in REQ or WAIT.
  - When it equals `TIMEOUT_CYCLES-1` and the current cycle does not complete the state, go to DONE with the fault flag set.
  - If the timeout hits in REQ, `bus_req_valid` drops (abort). This is the only legal valid withdrawal.
  - If the timeout hits on a load, `rsp_rdata` ← 0.
- **DONE**
  - `stall`=0 and `access_fault` = fault flag; the pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally. The fault flag clears.
- `stall` is combinational: `req_valid && state != DONE && !rst`.
- A `bus_rsp_valid` arriving outside WAIT (late response after timeout, or after reset) is ignored with no state change.
- A response in the same cycle as the request handshake is not legal; `bus_rsp_valid` is sampled only in WAIT.
- Response and timeout in the same cycle: the response wins and is captured normally, with fault only if `bus_rsp_err`.

## Timing
- **Reset values:** state IDLE, `bus_req_*`=0, `rsp_rdata`=0, `access_fault`=0, `stall`=0 while `rst` is high, counter 0.
- **Reset mid-access:** the FSM returns to IDLE immediately, and `bus_req_valid` deasserts asynchronously.
- **Minimum latency** (ready in the first REQ cycle, response the next cycle):
  - Cycle 0: IDLE with `req_valid`.
  - Cycle 1: REQ, handshake.
  - Cycle 2: WAIT, response.
  - Cycle 3: DONE.
  - `stall` is high in cycles 0–2 and low in cycle 3.
- Each extra cycle of `bus_req_ready` low or response delay adds one stall cycle.
- `rsp_rdata` is valid in DONE and held until the next load response.
- Back-to-back memory ops: after DONE→IDLE, the next op is seen in IDLE, so each access costs at least 4 cycles.

## Test plan
- **Zero-wait load:** `req_addr`=0x1000, ready immediate, `bus_rsp_rdata`=0x1122334455667788 one cycle after accept → `stall` high for 3 cycles, DONE with `rsp_rdata`=0x1122334455667788 and `access_fault`=0.
- **Store:** `req_wdata`=0x00000000AB000000, `byte_en`=0x08, addr 0x2008 → bus sees write=1, be=0x08, wdata=0x00000000AB000000, addr=0x2008; `rsp_rdata` unchanged.
- **Backpressure:** `bus_req_ready` low for 3 cycles → `bus_req_*` stable throughout, `stall` high for 6 cycles, completes normally.
- **Error response:** load with `bus_rsp_err`=1 → DONE with `access_fault`=1 for exactly one cycle and `rsp_rdata`=0.
- **Timeout:** `TIMEOUT_CYCLES`=8, ready immediate, no response → DONE 8 cycles after entering REQ with `access_fault`=1. A late `bus_rsp_valid` 2 cycles afterwards is ignored: state IDLE, no pulse.
- **Reset mid-WAIT:** assert `rst` for 1 cycle → `bus_req_valid`, `stall`, `access_fault`, `rsp_rdata` all 0 and state IDLE. The next load then completes normally.
